rf_packet_framer: RTL



---
 rtl/rf_transceiver_pkg.sv | 23 ++
 rtl/rf_idle_timer.sv | 29 ++
 rtl/rf_packet_framer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/rf_transceiver_pkg.sv
// Shared definitions for the RF transceiver slice: framer state encoding,
// default packet thresholds and header byte ordering.
package rf_transceiver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PL_RD,
    ST_PL_CAP,
    ST_PL_TX,
    ST_CSUM
  } framer_state_t;

  localparam int unsigned DEF_START_THRESHOLD = 58;
  localparam int unsigned DEF_MAX_PAYLOAD     = 58;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 4096;

  localparam logic [1:0] HDR_ADDH = 2'd0;
  localparam logic [1:0] HDR_ADDL = 2'd1;
  localparam logic [1:0] HDR_CHAN = 2'd2;
  localparam logic [1:0] HDR_LEN  = 2'd3;

endpackage

// File: rtl/rf_idle_timer.sv
// Saturating idle counter; expired stays high while the count sits at the limit.
module rf_idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic internal_clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] cnt;

  always_ff @(posedge internal_clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != TMAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == TMAX);

endmodule

// File: rtl/rf_packet_framer.sv
// Mode-0 transmit framer: drains the MCU FIFO into ADDH/ADDL/CHAN/LEN + payload
// + XOR checksum frames over a valid/ready byte interface.
module rf_packet_framer
  import rf_transceiver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned FIFO_DEPTH      = 512,
  parameter int unsigned CNT_WIDTH       = $clog2(FIFO_DEPTH + 1),
  parameter int unsigned START_THRESHOLD = DEF_START_THRESHOLD,
  parameter int unsigned MAX_PAYLOAD     = DEF_MAX_PAYLOAD,
  parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic                  internal_clk,
  input  logic                  rst_n,
  input  logic                  mode0_en,
  input  logic [7:0]            cfg_addh,
  input  logic [7:0]            cfg_addl,
  input  logic [7:0]            cfg_chan,
  input  logic [CNT_WIDTH-1:0]  fifo_count,
  input  logic                  fifo_empty,
  input  logic                  fifo_wr,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  pkt_done
);

  framer_state_t         state;
  logic [1:0]            hdr_idx;
  logic [7:0]            len_q;
  logic [7:0]            remaining;
  logic [7:0]            addh_q, addl_q, chan_q;
  logic [DATA_WIDTH-1:0] csum;
  logic [DATA_WIDTH-1:0] hdr_next;
  logic [CNT_WIDTH-1:0]  len_sel;
  logic                  has_data, timer_expired, start, accept;

  assign has_data = (fifo_count != '0);
  assign accept   = tx_valid && tx_ready;
  assign start    = (state == ST_IDLE) && mode0_en &&
                    ((fifo_count >= CNT_WIDTH'(START_THRESHOLD)) || (has_data && timer_expired));
  assign len_sel  = (fifo_count > CNT_WIDTH'(MAX_PAYLOAD)) ? CNT_WIDTH'(MAX_PAYLOAD) : fifo_count;

  // Pop is decoded from the state register so the FIFO's one-cycle read latency lands in PL_CAP.
  assign fifo_rd  = (state == ST_PL_RD) && !fifo_empty;

  rf_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .internal_clk(internal_clk),
    .rst_n       (rst_n),
    .clr         (fifo_wr || !has_data || start),
    .en          ((state == ST_IDLE) && has_data),
    .expired     (timer_expired)
  );

  // Byte that follows the header beat currently on the bus.
  always_comb begin
    hdr_next = DATA_WIDTH'(len_q);
    case (hdr_idx)
      HDR_ADDH: hdr_next = DATA_WIDTH'(addl_q);
      HDR_ADDL: hdr_next = DATA_WIDTH'(chan_q);
      default:  hdr_next = DATA_WIDTH'(len_q);
    endcase
  end

  always_ff @(posedge internal_clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hdr_idx   <= '0;
      len_q     <= '0;
      remaining <= '0;
      addh_q    <= '0;
      addl_q    <= '0;
      chan_q    <= '0;
      csum      <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      pkt_done  <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_HDR;
            hdr_idx   <= HDR_ADDH;
            len_q     <= 8'(len_sel);
            remaining <= 8'(len_sel);
            addh_q    <= cfg_addh;
            addl_q    <= cfg_addl;
            chan_q    <= cfg_chan;
            csum      <= '0;
            tx_data   <= DATA_WIDTH'(cfg_addh);
            tx_valid  <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_HDR: begin
          if (accept) begin
            csum <= csum ^ tx_data;
            if (hdr_idx == HDR_LEN) begin
              tx_valid <= 1'b0;
              state    <= ST_PL_RD;
            end else begin
              hdr_idx <= hdr_idx + 1'b1;
              tx_data <= hdr_next;
            end
          end
        end
        ST_PL_RD: begin
          if (fifo_empty) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= ST_PL_CAP;
          end
        end
        ST_PL_CAP: begin
          tx_data  <= fifo_rdata;
          tx_valid <= 1'b1;
          state    <= ST_PL_TX;
        end
        ST_PL_TX: begin
          if (accept) begin
            csum      <= csum ^ tx_data;
            remaining <= remaining - 1'b1;
            if (remaining == 8'd1) begin
              tx_data <= csum ^ tx_data;
              state   <= ST_CSUM;
            end else begin
              tx_valid <= 1'b0;
              state    <= ST_PL_RD;
            end
          end
        end
        ST_CSUM: begin
          if (accept) begin
            tx_valid <= 1'b0;
            pkt_done <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
